// File: rtl/dmem_access_ctrl.sv
// Memory-stage access sequencer: drives one load/store at a time onto a req/gnt/rvalid
// data-memory port, stalls the pipeline until the access completes, and flags misalignment/timeout.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_read_m_i,
    input  logic        mem_write_m_i,
    input  logic [31:0] addr_m_i,
    input  logic [31:0] write_data_m_i,
    input  logic [2:0]  width_src_m_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] read_data_m_o,
    output logic        stall_m_o,
    output logic        err_o
);

    // Width codes shared with the load-reduce logic; the _U variants are zero-extending loads.
    localparam logic [2:0] WIDTH_BYTE   = 3'b000;
    localparam logic [2:0] WIDTH_HALF   = 3'b001;
    localparam logic [2:0] WIDTH_BYTE_U = 3'b100;
    localparam logic [2:0] WIDTH_HALF_U = 3'b101;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_byte;
    logic             is_half;
    logic [1:0]       byte_off;
    logic             aligned;
    logic             access;
    logic             start;
    logic             misaligned;
    logic             timeout_hit;
    logic             capture;
    logic             abort;
    logic             in_bus_q;
    logic             in_bus_d;
    logic [3:0]       be_next;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (width_src_m_i)
            WIDTH_BYTE, WIDTH_BYTE_U: is_byte = 1'b1;
            WIDTH_HALF, WIDTH_HALF_U: is_half = 1'b1;
            default: ;
        endcase
    end

    assign byte_off    = addr_m_i[1:0];
    assign aligned     = is_byte || (is_half && !byte_off[0]) || (!is_byte && !is_half && byte_off == 2'b00);
    assign access      = mem_read_m_i || mem_write_m_i;
    assign start       = (state_q == S_IDLE) && access && aligned;
    assign misaligned  = (state_q == S_IDLE) && access && !aligned;
    assign be_next     = is_byte ? (4'b0001 << byte_off) : (is_half ? (4'b0011 << byte_off) : 4'b1111);
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign in_bus_q    = (state_q == S_REQ) || (state_q == S_WAIT);
    assign in_bus_d    = (state_d == S_REQ) || (state_d == S_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completing handshake in the final allowed cycle still wins over the timeout.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i && (dmem_we_o || dmem_rvalid_i)) begin
                    state_d = S_DONE;
                    capture = !dmem_we_o;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = (state_q == S_REQ);
        stall_m_o  = start || in_bus_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else if (in_bus_q && in_bus_d) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Request fields are frozen at acceptance so they stay stable while waiting for gnt.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_be_o    <= '0;
        end else if (start) begin
            dmem_we_o    <= mem_write_m_i;
            dmem_addr_o  <= {addr_m_i[31:2], 2'b00};
            dmem_wdata_o <= write_data_m_i << {byte_off, 3'b000};
            dmem_be_o    <= be_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            read_data_m_o <= '0;
            err_o         <= 1'b0;
        end else begin
            err_o <= misaligned || abort;
            if (capture) begin
                read_data_m_o <= dmem_rdata_i;
            end else if (abort) begin
                read_data_m_o <= '0;
            end
        end
    end

endmodule
